// File: rtl/dmi_pkg.sv
// Shared types for the two-host DMI arbiter: request ops, the BUSY status code
// and the transaction state encoding.
package dmi_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_type;

  localparam logic [1:0] DMI_OP_BUSY = 2'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_TOUT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/dmi_rr_arb2.sv
// Combinational two-way grant. A lone valid requester wins outright; on a tie
// the requester named by prio_i wins.
module dmi_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_o     = 2'b00;
    grant_idx_o = 1'b0;
    case (valid_i)
      2'b01: begin
        grant_o     = 2'b01;
        grant_idx_o = 1'b0;
      end
      2'b10: begin
        grant_o     = 2'b10;
        grant_idx_o = 1'b1;
      end
      2'b11: begin
        grant_o     = prio_i ? 2'b10 : 2'b01;
        grant_idx_o = prio_i;
      end
      default: begin
        grant_o     = 2'b00;
        grant_idx_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI Device between two Hosts with one outstanding transaction,
// round-robin grant and a response watchdog that answers BUSY on a stall.
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] h0_req_addr,
  input  logic [DATA_WIDTH-1:0] h0_req_data,
  input  logic [1:0]            h0_req_op,
  input  logic                  h0_req_valid,
  output logic                  h0_req_ready,
  output logic [DATA_WIDTH-1:0] h0_res_data,
  output logic [1:0]            h0_res_op,
  output logic                  h0_res_valid,
  input  logic                  h0_res_ready,
  input  logic [ADDR_WIDTH-1:0] h1_req_addr,
  input  logic [DATA_WIDTH-1:0] h1_req_data,
  input  logic [1:0]            h1_req_op,
  input  logic                  h1_req_valid,
  output logic                  h1_req_ready,
  output logic [DATA_WIDTH-1:0] h1_res_data,
  output logic [1:0]            h1_res_op,
  output logic                  h1_res_valid,
  input  logic                  h1_res_ready,
  output logic [ADDR_WIDTH-1:0] d_req_addr,
  output logic [DATA_WIDTH-1:0] d_req_data,
  output logic [1:0]            d_req_op,
  output logic                  d_req_valid,
  input  logic                  d_req_ready,
  input  logic [DATA_WIDTH-1:0] d_res_data,
  input  logic [1:0]            d_res_op,
  input  logic                  d_res_valid,
  output logic                  d_res_ready,
  output logic                  busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  owner_q, owner_d;
  logic                  late_seen_q, late_seen_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            op_q, op_d;

  logic [1:0]            grant;
  logic                  grant_idx;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic [1:0]            res_op;
  logic                  owner_ready;
  logic                  up_xfer;

  dmi_rr_arb2 u_arb (
    .valid_i     ({h1_req_valid, h0_req_valid}),
    .prio_i      (prio_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      late_seen_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      late_seen_q <= late_seen_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    late_seen_d = late_seen_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    res_valid   = 1'b0;
    res_data    = '0;
    res_op      = '0;
    d_res_ready = 1'b0;
    owner_ready = owner_q ? h1_res_ready : h0_res_ready;

    case (state_q)
      S_RESP: begin
        res_valid   = d_res_valid;
        res_data    = d_res_data;
        res_op      = d_res_op;
        d_res_ready = owner_ready;
      end
      S_TOUT: begin
        res_valid   = 1'b1;
        res_op      = DMI_OP_BUSY;
        d_res_ready = 1'b1;
      end
      S_DRAIN: d_res_ready = 1'b1;
      default: ;
    endcase

    up_xfer = res_valid && owner_ready;

    case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          addr_d  = grant_idx ? h1_req_addr : h0_req_addr;
          data_d  = grant_idx ? h1_req_data : h0_req_data;
          op_d    = grant_idx ? h1_req_op : h0_req_op;
          owner_d = grant_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (d_req_ready) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A completing transfer takes precedence over an expiring watchdog.
        if (up_xfer) begin
          prio_d  = ~owner_q;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          late_seen_d = 1'b0;
          state_d     = S_TOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TOUT: begin
        if (d_res_valid) late_seen_d = 1'b1;
        if (up_xfer) begin
          if (late_seen_q || d_res_valid) begin
            prio_d  = ~owner_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (d_res_valid) begin
          prio_d  = ~owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign h0_req_ready = (state_q == S_IDLE) && grant[0];
  assign h1_req_ready = (state_q == S_IDLE) && grant[1];

  assign h0_res_valid = res_valid && !owner_q;
  assign h1_res_valid = res_valid && owner_q;
  assign h0_res_data  = res_data;
  assign h1_res_data  = res_data;
  assign h0_res_op    = res_op;
  assign h1_res_op    = res_op;

  assign d_req_addr  = addr_q;
  assign d_req_data  = data_q;
  assign d_req_op    = op_q;
  assign d_req_valid = (state_q == S_REQ);

  assign busy = (state_q != S_IDLE);

endmodule
